l2_pmem_adapter: RTL

- Sits directly downstream of the L2 cache controller and datapath; converts full-line requests into fixed-length burst transactions on the physical memory bus.
- Accepts one 256-bit line read or write, performs 4 x 64-bit beats to memory, then returns a single-cycle line response upstream.
- Handles all beat sequencing, line (de)serialisation and address alignment, so the L2 controller sees a simple line-granular req/resp interface.

---
 rtl/l2_pkg.sv | 34 +++
 rtl/l2_pmem_adapter_if.sv | 40 ++++
 rtl/l2_line_shift_reg.sv | 41 ++++
 rtl/l2_pmem_adapter.sv | 132 +++++++++++++
 4 files changed

// File: rtl/l2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : l2_pkg
// Brief    : Shared widths, derived constants, FSM state type and address
//            alignment helper for the L2-to-physical-memory adapter.
// Revision : 1.0 - initial release
// ============================================================================
package l2_pkg;

  localparam int LINE_WIDTH  = 256;
  localparam int BURST_WIDTH = 64;
  localparam int ADDR_WIDTH  = 32;
  localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam int CNT_BITS    = $clog2(BEATS);

  // Byte-offset bits inside one line; cleared to form the burst base address.
  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK =
    ADDR_WIDTH'((64'd1 << OFFSET_BITS) - 64'd1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } adapter_state_t;

  // Line-align a byte address (drops the offset within the line).
  function automatic logic [ADDR_WIDTH-1:0] align_addr(input logic [ADDR_WIDTH-1:0] a);
    return a & ~OFFSET_MASK;
  endfunction

endpackage
`default_nettype wire

// File: rtl/l2_pmem_adapter_if.sv
`default_nettype none
// ============================================================================
// Module   : l2_pmem_adapter_if
// Brief    : Line-side (L2) and burst-side (memory) signals of the adapter.
//            Port directions in the names are from the adapter's viewpoint.
// Revision : 1.0 - initial release
// ============================================================================
interface l2_pmem_adapter_if;
  import l2_pkg::*;

  logic                   line_read_i;
  logic                   line_write_i;
  logic [ADDR_WIDTH-1:0]  line_addr_i;
  logic [LINE_WIDTH-1:0]  line_wdata_i;
  logic [LINE_WIDTH-1:0]  line_rdata_o;
  logic                   line_resp_o;
  logic                   mem_read_o;
  logic                   mem_write_o;
  logic [ADDR_WIDTH-1:0]  mem_addr_o;
  logic [BURST_WIDTH-1:0] mem_wdata_o;
  logic [BURST_WIDTH-1:0] mem_rdata_i;
  logic                   mem_resp_i;

  // Adapter side.
  modport slave (
    input  line_read_i, line_write_i, line_addr_i, line_wdata_i,
    input  mem_rdata_i, mem_resp_i,
    output line_rdata_o, line_resp_o,
    output mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o
  );

  // Environment side: L2 controller plus physical memory.
  modport master (
    output line_read_i, line_write_i, line_addr_i, line_wdata_i,
    output mem_rdata_i, mem_resp_i,
    input  line_rdata_o, line_resp_o,
    input  mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o
  );
endinterface
`default_nettype wire

// File: rtl/l2_line_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : l2_line_shift_reg
// Brief    : Beat-indexed line register. Loads a full line, writes one slice
//            at an index, and presents the slice at that index.
// Revision : 1.0 - initial release
// ============================================================================
module l2_line_shift_reg #(
  parameter int LINE_W  = 256,
  parameter int SLICE_W = 64,
  parameter int IDX_W   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [LINE_W-1:0]  line_i,
  input  logic               wr_i,
  input  logic [IDX_W-1:0]   idx_i,
  input  logic [SLICE_W-1:0] slice_i,
  output logic [LINE_W-1:0]  line_o,
  output logic [SLICE_W-1:0] slice_o
);

  logic [LINE_W-1:0] line_q;

  // Full-line load has priority over a single-slice write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
    end else if (load_i) begin
      line_q <= line_i;
    end else if (wr_i) begin
      line_q[idx_i*SLICE_W +: SLICE_W] <= slice_i;
    end
  end

  assign line_o  = line_q;
  assign slice_o = line_q[idx_i*SLICE_W +: SLICE_W];

endmodule
`default_nettype wire

// File: rtl/l2_pmem_adapter.sv
`default_nettype none
// ============================================================================
// Module   : l2_pmem_adapter
// Brief    : Converts line-granular L2 read/write requests into fixed-length
//            bursts of BEATS beats on the physical memory bus and returns a
//            single-cycle line response.
// Revision : 1.0 - initial release
// ============================================================================
module l2_pmem_adapter
  import l2_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  l2_pmem_adapter_if.slave bus
);

  adapter_state_t          state_q, state_d;
  logic [CNT_BITS-1:0]     cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LINE_WIDTH-1:0]   rdata_q;

  logic                    buf_load;
  logic                    buf_wr;
  logic                    rdata_load;
  logic                    last_beat;
  logic [LINE_WIDTH-1:0]   buf_line;
  logic [LINE_WIDTH-1:0]   fill_line;
  logic [BURST_WIDTH-1:0]  buf_slice;

  // One buffer serves both directions: it holds the writeback line during a
  // write burst and collects beats during a read burst. The returned fill
  // line lives in a separate register so a writeback cannot disturb it.
  l2_line_shift_reg #(
    .LINE_W  (LINE_WIDTH),
    .SLICE_W (BURST_WIDTH),
    .IDX_W   (CNT_BITS)
  ) u_line_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (buf_load),
    .line_i  (bus.line_wdata_i),
    .wr_i    (buf_wr),
    .idx_i   (cnt_q),
    .slice_i (bus.mem_rdata_i),
    .line_o  (buf_line),
    .slice_o (buf_slice)
  );

  assign last_beat = (cnt_q == CNT_BITS'(BEATS - 1));

  // Merge the final beat straight into the collected line so the fill
  // register can be loaded on the last acknowledge.
  always_comb begin
    fill_line = buf_line;
    fill_line[cnt_q*BURST_WIDTH +: BURST_WIDTH] = bus.mem_rdata_i;
  end

  // Next-state, beat counter and request latching; write wins over read.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    buf_load   = 1'b0;
    buf_wr     = 1'b0;
    rdata_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.line_write_i) begin
          state_d  = WR_BURST;
          addr_d   = align_addr(bus.line_addr_i);
          cnt_d    = '0;
          buf_load = 1'b1;
        end else if (bus.line_read_i) begin
          state_d  = RD_BURST;
          addr_d   = align_addr(bus.line_addr_i);
          cnt_d    = '0;
        end
      end
      RD_BURST: begin
        if (bus.mem_resp_i) begin
          buf_wr = 1'b1;
          cnt_d  = cnt_q + CNT_BITS'(1);
          if (last_beat) begin
            rdata_load = 1'b1;
            state_d    = DONE;
          end
        end
      end
      WR_BURST: begin
        if (bus.mem_resp_i) begin
          cnt_d = cnt_q + CNT_BITS'(1);
          if (last_beat) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter, latched address and completed fill line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      if (rdata_load) begin
        rdata_q <= fill_line;
      end
    end
  end

  // Outputs decode the registered state, so reset drops them immediately.
  assign bus.mem_read_o   = (state_q == RD_BURST);
  assign bus.mem_write_o  = (state_q == WR_BURST);
  assign bus.line_resp_o  = (state_q == DONE);
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_wdata_o  = (state_q == WR_BURST) ? buf_slice : '0;
  assign bus.line_rdata_o = rdata_q;

endmodule
`default_nettype wire
